// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common data bus (CDB) arbiter and its consumers.
// Consumers wrap the cdb_* outputs into cdb_t.
package cdb_arbiter_pkg;

  localparam int NUM_FU              = 4;
  localparam int BUF_DEPTH           = 2;
  localparam int DATA_WIDTH          = 32;
  localparam int PHYS_REG_ADDR_WIDTH = 6;
  localparam int ROB_IDX_WIDTH       = 5;

  typedef enum logic [1:0] {
    FU_ARITH  = 2'd0,
    FU_MEM    = 2'd1,
    FU_BR     = 2'd2,
    FU_MULDIV = 2'd3
  } fu_id_e;

  typedef struct packed {
    logic [PHYS_REG_ADDR_WIDTH-1:0] rd_paddr;
    logic [DATA_WIDTH-1:0]          rd_data;
    logic [ROB_IDX_WIDTH-1:0]       rob_idx;
  } fu_result_t;

  typedef struct packed {
    logic                           valid;
    logic [PHYS_REG_ADDR_WIDTH-1:0] rd_paddr;
    logic [DATA_WIDTH-1:0]          rd_data;
    logic [ROB_IDX_WIDTH-1:0]       rob_idx;
  } cdb_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/cdb_result_fifo.sv
// Small circular result buffer, one per functional unit. DEPTH must be a power of two
// so pointer wrap-around is plain overflow.
module cdb_result_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 43,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[head_q];
  // A full buffer refuses a push even if it is popped in the same cycle.
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) tail_d = tail_q + AW'(1);
      if (pop_ok)  head_d = head_q + AW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[tail_q] <= wdata;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Buffers functional-unit results and broadcasts one per cycle on the CDB,
// choosing among non-empty buffers round-robin from rr_ptr.
module cdb_arbiter #(
  parameter int NUM_FU        = 4,
  parameter int BUF_DEPTH     = 2,
  parameter int DATA_WIDTH    = 32,
  parameter int PADDR_WIDTH   = 6,
  parameter int ROB_IDX_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [NUM_FU-1:0]               fu_valid,
  input  logic [NUM_FU*PADDR_WIDTH-1:0]   fu_rd_paddr,
  input  logic [NUM_FU*DATA_WIDTH-1:0]    fu_rd_data,
  input  logic [NUM_FU*ROB_IDX_WIDTH-1:0] fu_rob_idx,
  output logic [NUM_FU-1:0]               fu_ready,
  output logic                            cdb_valid,
  output logic [PADDR_WIDTH-1:0]          cdb_rd_paddr,
  output logic [DATA_WIDTH-1:0]           cdb_rd_data,
  output logic [ROB_IDX_WIDTH-1:0]        cdb_rob_idx
);
  import cdb_arbiter_pkg::*;

  localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int EW = PADDR_WIDTH + DATA_WIDTH + ROB_IDX_WIDTH;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [NUM_FU-1:0]        fifo_full, fifo_empty, push, pop;
  logic [EW-1:0]            head [NUM_FU];
  logic [CW-1:0]            cnt  [NUM_FU];

  logic [PW-1:0]            rr_ptr_q, rr_ptr_d;
  logic                     cdb_valid_q, cdb_valid_d;
  logic [PADDR_WIDTH-1:0]   cdb_paddr_q, cdb_paddr_d;
  logic [DATA_WIDTH-1:0]    cdb_data_q, cdb_data_d;
  logic [ROB_IDX_WIDTH-1:0] cdb_rob_q, cdb_rob_d;

  logic                     found;
  logic [PW-1:0]            win, idx;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    // Ready comes from the registered count only, never from this cycle's pop.
    assign fu_ready[i] = (cnt[i] < CW'(BUF_DEPTH));
    assign push[i]     = fu_valid[i] && fu_ready[i] && !fifo_full[i] && !flush;

    cdb_result_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (EW)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push[i]),
      .pop   (pop[i]),
      .wdata ({fu_rd_paddr[i*PADDR_WIDTH +: PADDR_WIDTH],
               fu_rd_data[i*DATA_WIDTH +: DATA_WIDTH],
               fu_rob_idx[i*ROB_IDX_WIDTH +: ROB_IDX_WIDTH]}),
      .rdata (head[i]),
      .full  (fifo_full[i]),
      .empty (fifo_empty[i]),
      .count (cnt[i])
    );
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = PW'((int'(rr_ptr_q) + k) % NUM_FU);
      if (!found && !fifo_empty[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    pop         = '0;
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_paddr_d = cdb_paddr_q;
    cdb_data_d  = cdb_data_q;
    cdb_rob_d   = cdb_rob_q;
    if (flush) begin
      rr_ptr_d = '0;
    end else if (found) begin
      pop[win]    = 1'b1;
      cdb_valid_d = 1'b1;
      {cdb_paddr_d, cdb_data_d, cdb_rob_d} = head[win];
      rr_ptr_d    = PW'(rr_next(int'(win), NUM_FU));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_paddr_q <= '0;
      cdb_data_q  <= '0;
      cdb_rob_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_paddr_q <= cdb_paddr_d;
      cdb_data_q  <= cdb_data_d;
      cdb_rob_q   <= cdb_rob_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_rd_paddr = cdb_paddr_q;
  assign cdb_rd_data  = cdb_data_q;
  assign cdb_rob_idx  = cdb_rob_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: per-FU queues of accepted results and a
// round-robin pick give the expected bus contents each cycle.
module tb_cdb_arbiter;

  localparam int N   = 4;
  localparam int D   = 2;
  localparam int DW  = 32;
  localparam int PAW = 6;
  localparam int RW  = 5;
  localparam int EW  = PAW + DW + RW;

  logic              clk = 1'b0;
  logic              rst, flush;
  logic [N-1:0]      fu_valid;
  logic [N*PAW-1:0]  fu_rd_paddr;
  logic [N*DW-1:0]   fu_rd_data;
  logic [N*RW-1:0]   fu_rob_idx;
  logic [N-1:0]      fu_ready;
  logic              cdb_valid;
  logic [PAW-1:0]    cdb_rd_paddr;
  logic [DW-1:0]     cdb_rd_data;
  logic [RW-1:0]     cdb_rob_idx;

  always #5 clk = ~clk;

  cdb_arbiter #(
    .NUM_FU(N), .BUF_DEPTH(D), .DATA_WIDTH(DW), .PADDR_WIDTH(PAW), .ROB_IDX_WIDTH(RW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .fu_valid     (fu_valid),
    .fu_rd_paddr  (fu_rd_paddr),
    .fu_rd_data   (fu_rd_data),
    .fu_rob_idx   (fu_rob_idx),
    .fu_ready     (fu_ready),
    .cdb_valid    (cdb_valid),
    .cdb_rd_paddr (cdb_rd_paddr),
    .cdb_rd_data  (cdb_rd_data),
    .cdb_rob_idx  (cdb_rob_idx)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: results accepted but not yet broadcast, per FU, in acceptance order.
  logic [EW-1:0]  exp_q [N][$];
  logic           m_valid;
  logic [PAW-1:0] m_paddr;
  logic [DW-1:0]  m_data;
  logic [RW-1:0]  m_rob;
  int             m_rr;
  logic [N-1:0]   hold;
  logic [N-1:0]   force_en;
  logic [EW-1:0]  force_ent [N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) exp_q[i].delete();
    m_valid = 1'b0;
    m_paddr = '0;
    m_data  = '0;
    m_rob   = '0;
    m_rr    = 0;
    hold    = '0;
  endtask

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (exp_q[i].size() < D);
    return r;
  endfunction

  task automatic model_edge(input logic [N-1:0] rdy);
    int w;
    if (flush) begin
      for (int i = 0; i < N; i++) exp_q[i].delete();
      m_valid = 1'b0;
      m_rr    = 0;
      hold    = '0;
    end else begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && exp_q[(m_rr + k) % N].size() > 0) w = (m_rr + k) % N;
      if (w >= 0) begin
        {m_paddr, m_data, m_rob} = exp_q[w].pop_front();
        m_valid = 1'b1;
        m_rr    = (w + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (fu_valid[i] && rdy[i])
          exp_q[i].push_back({fu_rd_paddr[i*PAW +: PAW], fu_rd_data[i*DW +: DW],
                              fu_rob_idx[i*RW +: RW]});
        hold[i] = fu_valid[i] && !rdy[i];
      end
    end
  endtask

  // One cycle: check outputs at the falling edge, drive new inputs, advance the model at the rising edge.
  task automatic step(input logic [N-1:0] mask, input logic fl);
    logic [N-1:0] rdy;
    logic [EW-1:0] ent;
    @(negedge clk);
    rdy = model_ready();
    check("cdb_valid", 64'(cdb_valid), 64'(m_valid));
    check("cdb_rd_paddr", 64'(cdb_rd_paddr), 64'(m_paddr));
    check("cdb_rd_data", 64'(cdb_rd_data), 64'(m_data));
    check("cdb_rob_idx", 64'(cdb_rob_idx), 64'(m_rob));
    check("fu_ready", 64'(fu_ready), 64'(rdy));
    flush = fl;
    for (int i = 0; i < N; i++) begin
      if (force_en[i] || !hold[i]) begin
        if (force_en[i]) begin
          ent = force_ent[i];
          fu_valid[i] = 1'b1;
        end else begin
          ent = {PAW'($urandom), $urandom, RW'($urandom)};
          fu_valid[i] = mask[i];
        end
        {fu_rd_paddr[i*PAW +: PAW], fu_rd_data[i*DW +: DW], fu_rob_idx[i*RW +: RW]} = ent;
      end
    end
    force_en = '0;
    @(posedge clk);
    model_edge(rdy);
  endtask

  function automatic logic [N-1:0] sparse_mask();
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = ($urandom_range(0, 3) == 0);
    return m;
  endfunction

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    fu_valid = '0;
    fu_rd_paddr = '0;
    fu_rd_data = '0;
    fu_rob_idx = '0;
    force_en = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    check("rst_fu_ready", 64'(fu_ready), 64'hf);
    check("rst_cdb_data", 64'(cdb_rd_data), 64'd0);
    repeat (5) step('0, 1'b0);

    // Single FU0 result: bus shows it only after the second edge, for one cycle.
    force_en[0] = 1'b1;
    force_ent[0] = {6'd5, 32'hDEADBEEF, 5'd3};
    step(4'b0001, 1'b0);
    #1 check("single_no_bypass", 64'(cdb_valid), 64'd0);
    step('0, 1'b0);
    #1 check("single_valid", 64'(cdb_valid), 64'd1);
    check("single_paddr", 64'(cdb_rd_paddr), 64'd5);
    check("single_data", 64'(cdb_rd_data), 64'hDEADBEEF);
    check("single_rob", 64'(cdb_rob_idx), 64'd3);
    step('0, 1'b0);
    #1 check("single_one_cycle", 64'(cdb_valid), 64'd0);

    // Flush to park rr_ptr at 0, then all four FUs at once.
    step('0, 1'b1);
    for (int i = 0; i < N; i++) begin
      force_en[i] = 1'b1;
      force_ent[i] = {PAW'(i + 1), $urandom, RW'(i)};
    end
    step('1, 1'b0);
    for (int k = 0; k < N; k++) begin
      step('0, 1'b0);
      #1 check("all4_valid", 64'(cdb_valid), 64'd1);
      check("all4_order", 64'(cdb_rd_paddr), 64'(k + 1));
    end
    step('0, 1'b0);

    // Build up FU0/FU1 backlog, then flush alongside a fresh FU2 result.
    repeat (4) step(4'b0011, 1'b0);
    step(4'b0111, 1'b1);
    #1 check("flush_valid", 64'(cdb_valid), 64'd0);
    check("flush_ready", 64'(fu_ready), 64'hf);
    repeat (6) step('0, 1'b0);

    repeat (400) step(N'($urandom), ($urandom_range(0, 39) == 0));
    repeat (200) step('1, 1'b0);
    repeat (200) step(sparse_mask(), 1'b0);
    repeat (100) step(4'b0101, 1'b0);

    // Asynchronous reset while a broadcast is on the bus.
    step('0, 1'b1);
    step('1, 1'b0);
    step('0, 1'b0);
    #1 check("pre_rst_valid", 64'(cdb_valid), 64'd1);
    #1 rst = 1'b1;
    #1 check("async_rst_valid", 64'(cdb_valid), 64'd0);
    check("async_rst_ready", 64'(fu_ready), 64'hf);
    check("async_rst_paddr", 64'(cdb_rd_paddr), 64'd0);
    check("async_rst_data", 64'(cdb_rd_data), 64'd0);
    model_reset();
    fu_valid = '0;
    flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (100) step(N'($urandom), 1'b0);
    step('0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
